// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
//   Groups the frame-request inputs and the datapath control outputs of the
//   UART transmit controller.
//
//   DATA_VALID : frame request; the data sits on the shared P_DATA bus
//   PAR_EN     : parity enable, taken when a frame is accepted
//   ser_load   : one-cycle pulse, serializer loads P_DATA
//   ser_shift  : one-cycle pulse, serializer advances one bit
//   par_en     : 0 = parity block tracks data, 1 = data frozen, PAR_BIT computed
//   mux_sel    : TX line source (00 start, 01 data, 10 parity, 11 stop/idle)
//   busy       : a frame is in progress
//   tx_done    : one-cycle pulse on the last cycle of the stop bit
//
//   master : frame requester (drives DATA_VALID / PAR_EN)
//   slave  : the controller
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       ser_load;
    logic       ser_shift;
    logic       par_en;
    logic [1:0] mux_sel;
    logic       busy;
    logic       tx_done;

    modport master (
        output DATA_VALID,
        output PAR_EN,
        input  ser_load,
        input  ser_shift,
        input  par_en,
        input  mux_sel,
        input  busy,
        input  tx_done
    );

    modport slave (
        input  DATA_VALID,
        input  PAR_EN,
        output ser_load,
        output ser_shift,
        output par_en,
        output mux_sel,
        output busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//   Frame sequencer for a UART transmitter. Walks START, DATA_WIDTH data bits,
//   an optional parity bit and STOP, each lasting CLKS_PER_BIT clocks, and
//   drives the serializer, parity block and TX line mux. All outputs are
//   registered.
//
//   Parameters
//     CLKS_PER_BIT : clocks per UART bit (>= 2)
//     DATA_WIDTH   : data bits per frame
//
//   Ports
//     clk  : clock, rising edge
//     rst  : synchronous active-high reset
//     bus  : uart_tx_ctrl_if.slave (DATA_VALID, PAR_EN in; control pulses,
//            par_en, mux_sel, busy, tx_done out)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | line at stop level, waiting for DATA_VALID
//   START  | start bit on the line; serializer loaded on first cycle
//   DATA   | data bits, serializer shifted at the end of each bit
//   PARITY | parity bit on the line (only when parity was accepted)
//   STOP   | stop bit; a new request on its last cycle chains a frame
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_ctrl_if.slave  bus
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_WIDTH - 1);

    localparam logic [1:0] SEL_START  = 2'b00;
    localparam logic [1:0] SEL_DATA   = 2'b01;
    localparam logic [1:0] SEL_PARITY = 2'b10;
    localparam logic [1:0] SEL_STOP   = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t          state_q,     state_d;
    logic [TW-1:0]   timer_q,     timer_d;
    logic [BW-1:0]   bit_cnt_q,   bit_cnt_d;
    logic            cfg_par_q,   cfg_par_d;

    logic            ser_load_q,  ser_load_d;
    logic            ser_shift_q, ser_shift_d;
    logic            par_en_q,    par_en_d;
    logic [1:0]      mux_sel_q,   mux_sel_d;
    logic            busy_q,      busy_d;
    logic            tx_done_q,   tx_done_d;

    logic            bit_end;

    // -----------------------------------------------------------------------
    // State register and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            cfg_par_q   <= 1'b0;
            ser_load_q  <= 1'b0;
            ser_shift_q <= 1'b0;
            par_en_q    <= 1'b0;
            mux_sel_q   <= SEL_STOP;
            busy_q      <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            cfg_par_q   <= cfg_par_d;
            ser_load_q  <= ser_load_d;
            ser_shift_q <= ser_shift_d;
            par_en_q    <= par_en_d;
            mux_sel_q   <= mux_sel_d;
            busy_q      <= busy_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next state, bit timer, bit counter, parity config
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + TW'(1);
        bit_cnt_d = bit_cnt_q;
        cfg_par_d = cfg_par_q;
        bit_end   = (timer_q == TIMER_LAST);

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (bus.DATA_VALID) begin
                    state_d   = START;
                    cfg_par_d = bus.PAR_EN;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    timer_d   = '0;
                    bit_cnt_d = '0;
                end
            end

            DATA: begin
                if (bit_end) begin
                    // Timer restarts for every data bit, not just on exit.
                    timer_d   = '0;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d = cfg_par_q ? PARITY : STOP;
                    end
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    timer_d = '0;
                end
            end

            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (bus.DATA_VALID) begin
                        // Back-to-back frame: skip IDLE, take fresh parity config.
                        state_d   = START;
                        cfg_par_d = bus.PAR_EN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                timer_d   = '0;
                bit_cnt_d = '0;
                cfg_par_d = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. Outputs are a function of the *next* state/timer so the
    // registered versions line up with the cycle the state register enters.
    // -----------------------------------------------------------------------
    always_comb begin
        ser_load_d  = 1'b0;
        ser_shift_d = 1'b0;
        par_en_d    = 1'b1;
        busy_d      = 1'b1;
        tx_done_d   = 1'b0;
        mux_sel_d   = SEL_STOP;

        case (state_d)
            IDLE: begin
                par_en_d = 1'b0;
                busy_d   = 1'b0;
            end
            START: begin
                mux_sel_d  = SEL_START;
                // Timer clears on every entry, so timer 0 marks the first cycle.
                ser_load_d = (timer_d == '0);
            end
            DATA: begin
                mux_sel_d   = SEL_DATA;
                ser_shift_d = (timer_d == TIMER_LAST);
            end
            PARITY: begin
                mux_sel_d = SEL_PARITY;
            end
            STOP: begin
                mux_sel_d = SEL_STOP;
                tx_done_d = (timer_d == TIMER_LAST);
            end
            default: begin
                par_en_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    assign bus.ser_load  = ser_load_q;
    assign bus.ser_shift = ser_shift_q;
    assign bus.par_en    = par_en_q;
    assign bus.mux_sel   = mux_sel_q;
    assign bus.busy      = busy_q;
    assign bus.tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
//   Cycle-accurate bench for uart_tx_ctrl (CLKS_PER_BIT=4, DATA_WIDTH=8).
//   Each scenario fills per-cycle stimulus arrays and an expected output
//   array built from the frame layout (bit slots of C clocks each), then
//   plays the stimulus and compares every cycle.
//   Cycle k = the values seen #1 after rising edge k; inputs set at cycle k
//   are sampled by edge k+1.
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

    localparam int C    = 4;
    localparam int DW   = 8;
    localparam int MAXC = 1024;
    localparam logic [6:0] IDLE_V = 7'b11_0_0_0_0_0;

    logic clk;
    logic rst;

    uart_tx_ctrl_if bus ();

    uart_tx_ctrl #(
        .CLKS_PER_BIT (C),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    bit         dv  [MAXC];
    bit         pe  [MAXC];
    bit         rs  [MAXC];
    bit         acc [MAXC];
    logic [6:0] exp_v [MAXC];

    // {mux_sel[1:0], ser_load, ser_shift, par_en, busy, tx_done}
    function automatic logic [6:0] obs_vec();
        return {bus.mux_sel, bus.ser_load, bus.ser_shift, bus.par_en,
                bus.busy, bus.tx_done};
    endfunction

    task automatic clear_all();
        for (int i = 0; i < MAXC; i++) begin
            dv[i]    = 1'b0;
            pe[i]    = 1'b0;
            rs[i]    = 1'b0;
            acc[i]   = 1'b0;
            exp_v[i] = IDLE_V;
        end
    endtask

    task automatic apply(input int c);
        rst            = rs[c];
        bus.DATA_VALID = dv[c];
        bus.PAR_EN     = pe[c];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference frame: request driven at cycle s, so the frame occupies
    // cycles s+1 .. s+len. Slot 0 = start, 1..DW = data, then parity, stop.
    function automatic int fill_frame(input int s, input bit p);
        int len;
        len = (DW + 2 + int'(p)) * C;
        for (int r = 1; r <= len; r++) begin
            int         seg;
            int         ph;
            logic [1:0] m;
            seg = (r - 1) / C;
            ph  = (r - 1) % C;
            if (seg == 0)                 m = 2'b00;
            else if (seg <= DW)           m = 2'b01;
            else if (p && seg == DW + 1)  m = 2'b10;
            else                          m = 2'b11;
            exp_v[s + r] = {m, (r == 1), (seg >= 1 && seg <= DW && ph == C - 1),
                            1'b1, 1'b1, (r == len)};
        end
        return len;
    endfunction

    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_all();
        rs[0] = 1'b1; dv[0] = 1'b1;
        rs[1] = 1'b1; dv[1] = 1'b1;
        apply(0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            apply(c);
            vectors++;
            if (obs_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", c, obs_vec(), exp_v[c]);
            end
        end
    endtask

    task automatic test_no_parity();
        int len, n_shift, done_cyc;
        clear_all();
        dv[0] = 1'b1; pe[0] = 1'b0;
        len = fill_frame(0, 1'b0);
        n_shift  = 0;
        done_cyc = -1;
        apply(0);
        for (int c = 1; c <= len + 3; c++) begin
            tick();
            apply(c);
            if (bus.ser_shift === 1'b1) n_shift++;
            if (bus.tx_done === 1'b1) done_cyc = c;
            vectors++;
            if (obs_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL no_parity cyc=%0d got=%b exp=%b", c, obs_vec(), exp_v[c]);
            end
        end
        vectors++;
        if (n_shift !== 8) begin
            miscompares++;
            $display("FAIL no_parity_shift_count got=%0d exp=8", n_shift);
        end
        vectors++;
        if (done_cyc !== 40) begin
            miscompares++;
            $display("FAIL no_parity_done_cycle got=%0d exp=40", done_cyc);
        end
    endtask

    task automatic test_parity();
        int len, done_cyc;
        clear_all();
        dv[0] = 1'b1; pe[0] = 1'b1;
        len = fill_frame(0, 1'b1);
        done_cyc = -1;
        apply(0);
        for (int c = 1; c <= len + 3; c++) begin
            tick();
            apply(c);
            if (bus.tx_done === 1'b1) done_cyc = c;
            vectors++;
            if (obs_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL parity cyc=%0d got=%b exp=%b", c, obs_vec(), exp_v[c]);
            end
        end
        vectors++;
        if (done_cyc !== 44) begin
            miscompares++;
            $display("FAIL parity_done_cycle got=%0d exp=44", done_cyc);
        end
    endtask

    task automatic test_ignore();
        int len;
        clear_all();
        dv[0] = 1'b1; pe[0] = 1'b0;
        len = fill_frame(0, 1'b0);
        dv[10] = 1'b1;
        for (int c = 20; c < 30; c++) pe[c] = 1'b1;
        // Extra random requests only where the frame is busy and not ending.
        for (int c = 1; c < len; c++) begin
            if (exp_v[c][1] && !exp_v[c][0] && $urandom_range(0, 3) == 0) dv[c] = 1'b1;
            if (c < 20 && $urandom_range(0, 1) == 1) pe[c] = 1'b1;
        end
        apply(0);
        for (int c = 1; c <= len + 3; c++) begin
            tick();
            apply(c);
            vectors++;
            if (obs_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL ignore cyc=%0d got=%b exp=%b", c, obs_vec(), exp_v[c]);
            end
        end
    endtask

    task automatic test_back_to_back(input bit p1, input bit p2);
        int len1, len2;
        clear_all();
        dv[0] = 1'b1; pe[0] = p1;
        len1 = fill_frame(0, p1);
        dv[len1] = 1'b1; pe[len1] = p2;
        len2 = fill_frame(len1, p2);
        apply(0);
        for (int c = 1; c <= len1 + len2 + 3; c++) begin
            tick();
            apply(c);
            vectors++;
            if (obs_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL back_to_back p=%0d%0d cyc=%0d got=%b exp=%b",
                         p1, p2, c, obs_vec(), exp_v[c]);
            end
        end
    endtask

    task automatic test_mid_reset(input int rc, input bit p1, input bit p2);
        int len1, len2;
        clear_all();
        dv[0] = 1'b1; pe[0] = p1;
        len1 = fill_frame(0, p1);
        for (int c = rc + 1; c < MAXC; c++) exp_v[c] = IDLE_V;
        rs[rc] = 1'b1;
        dv[rc + 2] = 1'b1; pe[rc + 2] = p2;
        len2 = fill_frame(rc + 2, p2);
        apply(0);
        for (int c = 1; c <= rc + 2 + len2 + 3; c++) begin
            tick();
            apply(c);
            vectors++;
            if (obs_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL mid_reset rc=%0d cyc=%0d got=%b exp=%b",
                         rc, c, obs_vec(), exp_v[c]);
            end
        end
        if (len1 < rc) $display("note: reset cycle beyond first frame");
    endtask

    task automatic test_random();
        int cur, len, end_c, g;
        bit p;
        clear_all();
        cur   = 1;
        end_c = 0;
        for (int k = 0; k < 12; k++) begin
            p = 1'($urandom_range(0, 1));
            dv[cur]  = 1'b1;
            pe[cur]  = p;
            acc[cur] = 1'b1;
            len   = fill_frame(cur, p);
            end_c = cur + len;
            g     = $urandom_range(0, 3);   // 0 = chained on the stop cycle
            cur   = end_c + g;
        end
        for (int c = 0; c <= end_c + 3; c++) begin
            if (!acc[c]) begin
                pe[c] = 1'($urandom_range(0, 1));
                if (exp_v[c][1] && !exp_v[c][0] && $urandom_range(0, 2) == 0) dv[c] = 1'b1;
            end
        end
        apply(0);
        for (int c = 1; c <= end_c + 3; c++) begin
            tick();
            apply(c);
            vectors++;
            if (obs_vec() !== exp_v[c]) begin
                miscompares++;
                $display("FAIL random cyc=%0d got=%b exp=%b", c, obs_vec(), exp_v[c]);
            end
        end
    endtask

    // ------------------------------------------------------------------
    initial begin
        rst            = 1'b1;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN     = 1'b0;

        test_reset();
        test_no_parity();
        test_parity();
        test_ignore();
        test_back_to_back(1'b0, 1'b0);
        test_back_to_back(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        test_mid_reset(15, 1'b0, 1'b0);
        test_mid_reset($urandom_range(1, 39), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)));
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: clock cycles per UART bit, legal range >= 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame.
REQ-003 SHALL have port clk, input, 1: the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port DATA_VALID, input, 1: a frame request whose data is present on the shared P_DATA bus.
REQ-006 SHALL have port PAR_EN, input, 1: parity enable, sampled at frame accept.
REQ-007 SHALL have port ser_load, output, 1: one-cycle pulse that loads the serializer from P_DATA.
REQ-008 SHALL have port ser_shift, output, 1: one-cycle pulse that advances the serializer by one bit.
REQ-009 SHALL have port par_en, output, 1: low tracks/latches parity data; high freezes the data and computes PAR_BIT.
REQ-010 SHALL have port mux_sel, output, 2: TX line source; 00 = start (0), 01 = serial data, 10 = parity bit, 11 = stop/idle (1).
REQ-011 SHALL have port busy, output, 1: high while a frame is in progress.
REQ-012 SHALL have port tx_done, output, 1: one-cycle pulse on the last cycle of STOP.

Function
REQ-013 SHALL implement the FSM states IDLE, START, DATA, PARITY and STOP; all outputs SHALL be registered.
REQ-014 SHALL use a bit-timer that counts 0..CLKS_PER_BIT-1 in every non-IDLE state; bit_end means timer = CLKS_PER_BIT-1; the timer SHALL clear on every state entry.
REQ-015 Accept: in IDLE with DATA_VALID=1, the FSM SHALL enter START on the next edge and latch PAR_EN into cfg_par.
REQ-016 SHALL sequence the states as follows: START -> DATA at bit_end; DATA -> PARITY (cfg_par=1) or STOP (cfg_par=0) after the DATA_WIDTH-th data bit's bit_end; PARITY -> STOP at bit_end.
REQ-017 SHALL count data bits with a bit counter of width clog2(DATA_WIDTH+1) that is cleared on DATA entry and incremented at each DATA bit_end.
REQ-018 STOP at bit_end SHALL go to START when DATA_VALID=1 (back-to-back accept, cfg_par re-latched) and SHALL go to IDLE otherwise.
REQ-019 SHALL drive mux_sel to 00 in START, 01 in DATA, 10 in PARITY, and 11 in STOP and IDLE.
REQ-020 SHALL assert ser_load only on the first cycle of each START.
REQ-021 SHALL assert ser_shift on every DATA bit_end cycle, giving exactly DATA_WIDTH pulses per frame.
REQ-022 SHALL drive par_en to 0 in IDLE and 1 in every other state, so parity data is frozen from the first START cycle and PAR_BIT is valid before PARITY.
REQ-023 SHALL drive busy to 0 in IDLE only; tx_done SHALL be 1 only on the STOP bit_end cycle.
REQ-024 SHALL ignore DATA_VALID outside IDLE and outside the STOP bit_end cycle; changes to PAR_EN mid-frame SHALL have no effect.
REQ-025 Frame length from the first START cycle SHALL be (DATA_WIDTH+2+cfg_par)*CLKS_PER_BIT cycles.

Reset
REQ-026 rst=1 at any edge SHALL force: state IDLE, timer 0, bit counter 0, cfg_par 0, mux_sel 11, ser_load 0, ser_shift 0, par_en 0, busy 0, tx_done 0.
REQ-027 rst SHALL take priority over DATA_VALID; a frame interrupted by reset SHALL be abandoned with no tx_done.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8; accept edge = cycle 0)
REQ-028 Reset: rst=1 for 2 cycles with DATA_VALID=1 -> mux_sel=11, busy=0, par_en=0, and no pulses on any output.
REQ-029 No parity: DATA_VALID pulse, PAR_EN=0 -> START cycles 1-4 (ser_load at 1), DATA cycles 5-36 with ser_shift at 8, 12, ..., 36, STOP cycles 37-40 with tx_done at 40, busy=0 at 41.
REQ-030 Parity: same stimulus with PAR_EN=1 -> PARITY cycles 37-40 with mux_sel=10, STOP cycles 41-44, tx_done at 44, par_en=1 for cycles 1-44.
REQ-031 Ignore: DATA_VALID=1 at cycle 10 and PAR_EN toggled at cycle 20 during a no-parity frame -> timing identical to REQ-029 and no extra ser_load.
REQ-032 Back-to-back: DATA_VALID=1 at cycle 40 of REQ-029 -> tx_done at 40, START with ser_load at 41, busy stays 1, and mux_sel goes 11 -> 00 at 41.
REQ-033 Mid-frame reset: rst=1 at cycle 15 -> at 16 mux_sel=11, busy=0, par_en=0; a new DATA_VALID at 17 yields a full frame with START at 18-21.
